// File: rtl/muldiv_pkg.sv
// Shared RV32M divide definitions: funct3 codes, sequencer state encoding,
// special-case constants and the special-case result bundle.
package muldiv_pkg;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } div_state_e;

  typedef struct packed {
    logic        hit;
    logic [31:0] quotient;
    logic [31:0] remainder;
  } div_special_t;

  function automatic logic [31:0] sel_result(input logic        rem,
                                             input logic [31:0] quo,
                                             input logic [31:0] rmd);
    return rem ? rmd : quo;
  endfunction

endpackage

// File: rtl/div_special.sv
// Combinational detection of divide-by-zero and signed overflow, producing
// the architecturally defined quotient/remainder without using the divider.
module div_special
  import muldiv_pkg::*;
(
  input  logic [31:0]  rs1,
  input  logic [31:0]  rs2,
  input  logic         sign,
  output div_special_t result
);

  always_comb begin
    result = '0;
    if (rs2 == '0) begin
      result.hit       = 1'b1;
      result.quotient  = ALL_ONES;
      result.remainder = rs1;
    end else if (sign && (rs1 == INT_MIN) && (rs2 == ALL_ONES)) begin
      result.hit       = 1'b1;
      result.quotient  = INT_MIN;
      result.remainder = '0;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// RV32M divide sequencer in front of the iterative divider.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        flush,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_numerator,
  output logic [31:0] div_denominator,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done
);

  div_state_e   state_q, state_d;
  logic         rem_q, sign_q;
  logic [31:0]  rs1_q, rs2_q, result_q;
  logic         req_sign, req_rem, accept;
  logic         cache_hit;
  logic [31:0]  cache_result;
  logic         div_capture;
  div_special_t special;

  assign req_sign    = ~req_funct3[0];
  assign req_rem     = req_funct3[1];
  assign accept      = (state_q == IDLE) && req_valid && req_funct3[2] && !flush;
  assign div_capture = (state_q == WAIT) && div_done && !flush;

  div_special u_special (
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .sign   (req_sign),
    .result (special)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic        c_valid, c_sign;
  logic [31:0] c_rs1, c_rs2, c_quo, c_rem;

  assign cache_hit    = c_valid && (c_rs1 == req_rs1) && (c_rs2 == req_rs2) && (c_sign == req_sign);
  assign cache_result = sel_result(req_rem, c_quo, c_rem);

  // Drained results are never seen, so the entry is dropped rather than trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_sign  <= 1'b0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_quo   <= '0;
      c_rem   <= '0;
    end else if (div_capture) begin
      c_valid <= 1'b1;
      c_sign  <= sign_q;
      c_rs1   <= rs1_q;
      c_rs2   <= rs2_q;
      c_quo   <= div_quotient;
      c_rem   <= div_remainder;
    end else if ((state_d == DRAIN) && (state_q != DRAIN)) begin
      c_valid <= 1'b0;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (special.hit || cache_hit) ? RESP : START;
      START: state_d = flush ? DRAIN : WAIT;
      WAIT: begin
        if (flush)         state_d = div_done ? IDLE : DRAIN;
        else if (div_done) state_d = RESP;
      end
      DRAIN: if (div_done) state_d = IDLE;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rs1_q    <= '0;
      rs2_q    <= '0;
      sign_q   <= 1'b0;
      rem_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        sign_q <= req_sign;
        rem_q  <= req_rem;
        if (special.hit)
          result_q <= sel_result(req_rem, special.quotient, special.remainder);
        else if (cache_hit)
          result_q <= cache_result;
      end else if (div_capture) begin
        result_q <= sel_result(rem_q, div_quotient, div_remainder);
      end
    end
  end

  assign busy            = (state_q != IDLE);
  assign div_start       = (state_q == START);
  assign resp_valid      = (state_q == RESP) && !flush;
  assign resp_data       = result_q;
  assign div_sign        = sign_q;
  assign div_numerator   = rs1_q;
  assign div_denominator = rs2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: transaction-level reference model, a
// behavioural divider with random latency, and a per-cycle compare process.
module tb_div_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, flush;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic        busy, resp_valid, div_start, div_sign, div_done;
  logic [31:0] resp_data, div_numerator, div_denominator, div_quotient, div_remainder;

  div_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush), .busy(busy),
    .resp_valid(resp_valid), .resp_data(resp_data), .div_start(div_start),
    .div_sign(div_sign), .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // RV32M divide semantics straight from the ISA rules.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic sgn, rem;
    sgn = !f3[0];
    rem = f3[1];
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  // Current transaction: kind 0 none, 1 bypass (special/cache), 2 divider.
  int          t_kind = 0, t_acc = -1, t_f = -1, done_cyc = -1;
  logic [31:0] t_a = '0, t_b = '0, t_exp = '0;
  logic        t_sign = 1'b0;
  bit          c_v = 0;
  logic [31:0] c_a = '0, c_b = '0;
  logic        c_s = 1'b0;

  int          bfm_lat = 1, bfm_target = -1;
  logic [31:0] bfm_n, bfm_d;
  logic        bfm_s;

  function automatic bit drained();
    return (t_f >= 0) && (done_cyc >= 0) && (t_f <= done_cyc);
  endfunction

  function automatic int end_cyc();
    if (t_kind == 1) return t_acc + 1;
    if (t_kind == 0) return -1;
    if (done_cyc < 0) return 32'h7FFF_FFFF;
    return drained() ? done_cyc : done_cyc + 1;
  endfunction

  // Behavioural divider: samples operands at start, completes after bfm_lat cycles.
  initial begin
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(posedge clk); #1;
      div_done = 1'b0;
      div_quotient  = $urandom;
      div_remainder = $urandom;
      if (!rst && bfm_target >= 0 && cyc == bfm_target) begin
        div_done      = 1'b1;
        div_quotient  = ref_div({2'b10, ~bfm_s}, bfm_n, bfm_d);
        div_remainder = ref_div({2'b11, ~bfm_s}, bfm_n, bfm_d);
        done_cyc      = cyc;
        bfm_target    = -1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) bfm_target = -1;
    else if (div_start) begin
      bfm_target = cyc + bfm_lat;
      bfm_n = div_numerator; bfm_d = div_denominator; bfm_s = div_sign;
    end
  end

  // Per-cycle compare against the transaction model.
  initial forever begin
    int  rcyc;
    bit  e_busy, e_start, e_resp;
    @(negedge clk);
    rcyc = -5;
    if (t_kind == 1) rcyc = t_acc + 1;
    else if (t_kind == 2 && done_cyc >= 0 && !drained()) rcyc = done_cyc + 1;
    e_busy  = (t_kind != 0) && (cyc > t_acc) && (cyc <= end_cyc());
    e_start = (t_kind == 2) && (cyc == t_acc + 1);
    e_resp  = (t_kind != 0) && (cyc == rcyc) && (t_f != cyc);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("div_start", 32'(div_start), 32'(e_start));
    chk("resp_valid", 32'(resp_valid), 32'(e_resp));
    if (e_resp) chk("resp_data", resp_data, t_exp);
    if (cyc != t_acc) begin
      chk("div_numerator", div_numerator, t_a);
      chk("div_denominator", div_denominator, t_b);
      chk("div_sign", 32'(div_sign), 32'(t_sign));
    end
  end

  // Called and returns at posedge+2; foff/rst_off are cycle offsets from accept (<0 = none).
  task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int foff, input bit pre_flush,
                         input int rst_off, input logic [31:0] exp);
    int kind;
    bit sgn, was_reset;
    sgn = !f3[0];
    was_reset = 0;
    req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
    if (pre_flush) begin
      flush = 1'b1;
      @(posedge clk); #2;
      flush = 1'b0;
    end
    bfm_lat = lat;
    kind = (b == 32'd0 || (sgn && a == INT_MIN && b == ALL_ONES)) ? 1 : 2;
`ifdef DIV_RESULT_CACHE_EN
    if (kind == 2 && c_v && c_a == a && c_b == b && c_s == sgn) kind = 1;
`endif
    done_cyc = -1; t_a = a; t_b = b; t_sign = sgn; t_exp = exp;
    t_acc = cyc; t_f = (foff >= 0) ? cyc + foff : -1; t_kind = kind;
    forever begin
      @(posedge clk); #2;
      if (cyc > end_cyc()) break;
      if (cyc > t_acc + 100) begin
        chk("timeout", 32'(cyc), 32'(t_acc));
        break;
      end
      if (rst_off >= 0 && cyc == t_acc + rst_off) begin
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
        t_kind = 0; t_acc = -1; t_f = -1; t_a = '0; t_b = '0; t_sign = 1'b0;
        bfm_target = -1; c_v = 0;
        repeat (2) begin @(posedge clk); #2; end
        chk("rst_resp_data", resp_data, 32'd0);
        rst = 1'b0;
        was_reset = 1;
        break;
      end
      flush = (cyc == t_f);
      if (cyc == t_f) req_valid = 1'b0;
    end
    req_valid = 1'b0; flush = 1'b0;
    if (!was_reset && kind == 2 && done_cyc >= 0) begin
      if (t_f >= 0 && t_f < done_cyc) c_v = 0;
      else if (t_f != done_cyc) begin
        c_v = 1; c_a = a; c_b = b; c_s = sgn;
      end
    end
  endtask

  initial begin
    logic [31:0] a, b, last_a, last_b;
    logic [2:0]  f3;
    int          lat, foff;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
    last_a = 32'd77; last_b = 32'd5;

    chk("pin_div_neg", ref_div(DIV, 32'd100, 32'hFFFF_FFF9), 32'hFFFF_FFF2);
    chk("pin_rem_neg", ref_div(REM, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
    chk("pin_divu", ref_div(DIVU, 32'hFFFF_FFFF, 32'd16), 32'h0FFF_FFFF);

    repeat (3) begin @(posedge clk); #2; end
    chk("rst_resp_data", resp_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    run_req(DIV,  32'd100,      32'hFFFF_FFF9, 6, -1, 0, -1, 32'hFFFF_FFF2);
    run_req(REMU, 32'hFFFF_FFFF, 32'd16,       9, -1, 0, -1, 32'h0000_000F);
    run_req(DIV,  32'd1234,     32'd0,         3, -1, 0, -1, 32'hFFFF_FFFF);
    run_req(REM,  32'd1234,     32'd0,         3, -1, 0, -1, 32'd1234);
    run_req(DIV,  INT_MIN,      ALL_ONES,      3, -1, 0, -1, 32'h8000_0000);
    run_req(REM,  INT_MIN,      ALL_ONES,      3, -1, 0, -1, 32'd0);
    run_req(DIVU, INT_MIN,      ALL_ONES,      4, -1, 0, -1, 32'd0);
    run_req(DIV,  32'd1000,     32'd3,        12,  6, 0, -1, 32'd333);
    run_req(DIV,  32'd1000,     32'd3,         5, -1, 0, -1, 32'd333);
    run_req(DIV,  32'd77,       32'd5,         7, -1, 0, -1, 32'd15);
    run_req(REM,  32'd77,       32'd5,         7, -1, 0, -1, 32'd2);
    run_req(DIV,  32'd78,       32'd5,         4, -1, 0, -1, 32'd15);
    run_req(DIVU, 32'd9,        32'd2,         8,  3, 0, -1, 32'd4);
    run_req(REM,  32'd78,       32'd5,         5, -1, 0, -1, 32'd3);
    run_req(DIVU, 32'd50,       32'd7,         3, -1, 1, -1, 32'd7);
    run_req(DIV,  32'd500,      32'd9,         4,  5, 0, -1, 32'd55);
    run_req(REM,  32'd501,      32'd9,         4,  6, 0, -1, 32'd6);
    run_req(DIV,  32'd501,      32'd9,         4, -1, 0, -1, 32'd55);
    run_req(DIVU, 32'd64,       32'd8,         3,  1, 0, -1, 32'd8);

    req_funct3 = 3'b011; req_rs1 = 32'd42; req_rs2 = 32'd6; req_valid = 1'b1;
    repeat (4) begin @(posedge clk); #2; end
    req_valid = 1'b0;

    run_req(DIV,  32'd900,      32'd7,        10, -1, 0,  3, 32'd128);
    repeat (2) begin @(posedge clk); #2; end
    run_req(DIV,  32'd900,      32'd7,         4, -1, 0, -1, 32'd128);

    for (int i = 0; i < 300; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = INT_MIN; b = ALL_ONES; end
        2: begin a = last_a; b = last_b; end
        3: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        4: begin a = $urandom; b = -32'($urandom_range(1, 9)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      lat  = $urandom_range(1, 12);
      foff = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat + 2) : -1;
      run_req(f3, a, b, lat, foff, 0, -1, ref_div(f3, a, b));
      last_a = a; last_b = b;
    end

    repeat (3) begin @(posedge clk); #2; end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors %0d miscompares", vecs, errs);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing stage directly upstream of the signed/unsigned iterative divider. It accepts RV32M DIV/DIVU/REM/REMU requests from the execute stage and resolves divide-by-zero and signed-overflow cases locally. All other requests are latched into operand registers and handed to the divider with a start pulse. It then captures the divider result, selects quotient or remainder, and returns a single-cycle response while the pipeline stalls.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset; also drives the divider's rst.
- req_valid  in  1  EX-stage request; held high with stable fields until resp_valid.
- req_funct3  in  3  RV32M funct3; bit2 must be 1, bit1 = remainder, bit0 = unsigned.
- req_rs1  in  32  dividend.
- req_rs2  in  32  divisor.
- flush  in  1  pipeline kill; abandons the in-flight request.
- busy  out  1  high in every state except IDLE.
- resp_valid  out  1  one-cycle result strobe.
- resp_data  out  32  selected result, valid with resp_valid.
- div_start  out  1  one-cycle start pulse to the divider.
- div_sign  out  1  1 = signed operation.
- div_numerator  out  32  registered dividend, held stable until div_done.
- div_denominator  out  32  registered divisor, held stable until div_done.
- div_quotient  in  32  divider quotient.
- div_remainder  in  32  divider remainder.
- div_done  in  1  divider completion strobe.

## Operation
- States: IDLE, START, WAIT, DRAIN, RESP.
- IDLE: a request is accepted when req_valid=1, req_funct3[2]=1 and flush=0.
  - Requests with funct3[2]=0 are ignored and produce no response.
  - On accept, latch rs1, rs2, funct3, and the special-case result.
  - Special case or cache hit: go to RESP. Otherwise go to START.
- Special cases (bypass the divider):
  - rs2==0: quotient = 0xFFFFFFFF, remainder = rs1. Applies to both signed and unsigned.
  - Signed only, rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- START: div_start=1 for exactly one cycle, then go to WAIT.
- WAIT: on div_done, capture div_quotient and div_remainder (per funct3[1]) into the result register and go to RESP.
- RESP: resp_valid=1 and resp_data = result register; go to IDLE. The block does not accept in RESP, so a held req_valid is never double-accepted.
- flush:
  - In START or WAIT: go to DRAIN. DRAIN waits for div_done, discards the result, then goes to IDLE with no response.
  - In RESP: resp_valid is forced to 0 and the state still returns to IDLE.
  - In IDLE: blocks acceptance that cycle.
- div_done arriving in the same cycle as flush in WAIT: the result is discarded and the state goes directly to IDLE.
- div_numerator, div_denominator and div_sign come only from registers and change only on accept. The divider samples numerator bits throughout its iteration, so these must not change while it runs.

## Timing
- Reset values:
  - State = IDLE.
  - busy, resp_valid and div_start = 0.
  - resp_data, div_numerator and div_denominator = 0; div_sign = 0.
  - Cache entry invalid.
- Special case or cache hit: accept at cycle T, resp_valid at T+1.
- Divider path: accept at T, div_start at T+1, resp_valid one cycle after the div_done cycle.
- Pipeline stall = req_valid & ~resp_valid. EX advances on the edge ending the resp_valid cycle.
- Back-to-back requests: the earliest next accept is the cycle after resp_valid.
- rst asserted mid-operation: immediate return to IDLE, all outputs at reset values, no response. The divider is reset through the shared rst.

## Configuration
- DIV_RESULT_CACHE_EN defined:
  - A one-entry cache holds {valid, rs1, rs2, sign, quotient, remainder}, written on every completed divider operation.
  - A new request with matching rs1, rs2 and sign returns in 1 cycle without starting the divider. This covers the DIV followed by REM idiom.
  - The entry is invalidated on rst and on entry to DRAIN.
- DIV_RESULT_CACHE_EN undefined: no cache storage; every non-special request uses the divider.

## Structure
- muldiv_pkg holds:
  - funct3 constants: DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111.
  - The div_ctrl state enum.
  - Special constants: INT_MIN=32'h80000000 and ALL_ONES=32'hFFFFFFFF.
- Sub-module div_special: combinational special-case detect and result generation, returning {hit, quotient, remainder}.

## Test plan
- Divider path, DIV 100 / -7 → div_start one cycle after accept; resp_data = 0xFFFFFFF2 (-14) one cycle after div_done.
- Divider path, REMU 0xFFFFFFFF / 16 → resp_data = 0x0000000F; div_sign = 0 throughout.
- Divide-by-zero, DIV 1234 / 0 → resp_valid at T+1 with 0xFFFFFFFF; REM 1234 / 0 → 1234; div_start never asserts.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; both at T+1.
- Flush mid-operation: flush 5 cycles after div_start → no resp_valid; busy stays high until div_done, then IDLE; the next request completes correctly.
- Cache (DIV_RESULT_CACHE_EN only): DIV 77 / 5 → 15, then REM 77 / 5 → 2 at T+1 with no div_start. Repeat with flush between the two: REM re-runs through the divider.
